decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/calc_pkg.sv | 49 ++++
 rtl/decode_stage_if.sv | 43 ++++
 rtl/decode_stage_hazard.sv | 19 +
 rtl/decode_stage.sv | 100 ++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and types for the decode stage.
// Instruction layout: [13:12] ctrl, [11:8] A, [7:4] B, [3:0] D.
package calc_pkg;

  localparam int INST_W   = 14;
  localparam int RADDR_W  = 4;
  localparam int CTRL_W   = 2;

  // Field bit positions within an instruction word
  localparam int CTRL_LSB = 12;
  localparam int A_LSB    = 8;
  localparam int B_LSB    = 4;
  localparam int D_LSB    = 0;

  // ALU operations carried in the ctrl field
  typedef enum logic [CTRL_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_t;

  // ID register: the whole decoded instruction plus its valid flag
  typedef struct packed {
    logic               valid;
    op_t                ctrl;
    logic [RADDR_W-1:0] a;
    logic [RADDR_W-1:0] b;
    logic [RADDR_W-1:0] d;
  } id_reg_t;

  // EX register: only the destination survives past issue
  typedef struct packed {
    logic               valid;
    logic [RADDR_W-1:0] d;
  } ex_reg_t;

  // Split a raw instruction word into ID register fields
  function automatic id_reg_t unpack_inst(input logic [INST_W-1:0] inst);
    id_reg_t r;
    r.valid = 1'b1;
    r.ctrl  = op_t'(inst[CTRL_LSB +: CTRL_W]);
    r.a     = inst[A_LSB +: RADDR_W];
    r.b     = inst[B_LSB +: RADDR_W];
    r.d     = inst[D_LSB +: RADDR_W];
    return r;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: bundle between instruction memory / PC, the decode
// stage and the register file / ALU.
//
// Handshake: inst_in is consumed on a rising clk edge when inst_valid=1 and
// stall=0. While stall=1 nothing is consumed and the source (PC counter)
// must keep presenting the same instruction. issue_valid marks a cycle in
// which ctrl/addr_a/addr_b carry an issued instruction; there is no
// back-pressure on the issue side.
interface decode_stage_if #(
  parameter int INST_W  = 14,
  parameter int RADDR_W = 4,
  parameter int CNT_W   = 16
);

  logic [INST_W-1:0]  inst_in;
  logic               inst_valid;
  logic               stall;
  logic [1:0]         ctrl;
  logic [RADDR_W-1:0] addr_a;
  logic [RADDR_W-1:0] addr_b;
  logic               issue_valid;
  logic               wb_en;
  logic [RADDR_W-1:0] wb_addr;
  logic               fwd_a;
  logic               fwd_b;
  logic [CNT_W-1:0]   issue_count;
  logic [7:0]         stall_count;

  // Fetch side / environment
  modport master (
    output inst_in, inst_valid,
    input  stall, ctrl, addr_a, addr_b, issue_valid, wb_en, wb_addr,
    input  fwd_a, fwd_b, issue_count, stall_count
  );

  // Decode stage
  modport slave (
    input  inst_in, inst_valid,
    output stall, ctrl, addr_a, addr_b, issue_valid, wb_en, wb_addr,
    output fwd_a, fwd_b, issue_count, stall_count
  );

endinterface

// File: rtl/decode_stage_hazard.sv
// hazard_unit: read-after-write compare between the instruction in ID and
// the one issued last cycle (sitting in EX). Every register address,
// including 0, is a real dependency.
module hazard_unit #(
  parameter int RADDR_W = 4
) (
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_a,
  input  logic [RADDR_W-1:0] id_b,
  input  logic               ex_valid,
  input  logic [RADDR_W-1:0] ex_d,
  output logic               hazard_a,
  output logic               hazard_b
);

  assign hazard_a = id_valid & ex_valid & (id_a == ex_d);
  assign hazard_b = id_valid & ex_valid & (id_b == ex_d);

endmodule

// File: rtl/decode_stage.sv
// decode_stage: single-issue decode with ID and EX registers, RAW hazard
// detection against the EX destination, and issue/stall counters.
// Optional macro DECODE_FWD_EN: hazards select the registered ALU result
// (fwd_a/fwd_b) instead of stalling. Default build stalls one cycle.
module decode_stage
  import calc_pkg::*;
#(
  parameter int INST_W  = calc_pkg::INST_W,
  parameter int RADDR_W = calc_pkg::RADDR_W,
  parameter int CNT_W   = 16
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);

  id_reg_t           id_q;
  ex_reg_t           ex_q;
  logic [INST_W-1:0] inst;
  logic              hazard_a;
  logic              hazard_b;
  logic              stall_c;
  logic              fwd_a_c;
  logic              fwd_b_c;
  logic              issue;
  logic [CNT_W-1:0]  issue_cnt_q;
  logic [7:0]        stall_cnt_q;

  assign inst = bus.inst_in;

  hazard_unit #(.RADDR_W(RADDR_W)) u_hazard (
    .id_valid (id_q.valid),
    .id_a     (id_q.a),
    .id_b     (id_q.b),
    .ex_valid (ex_q.valid),
    .ex_d     (ex_q.d),
    .hazard_a (hazard_a),
    .hazard_b (hazard_b)
  );

`ifdef DECODE_FWD_EN
  // Forwarding resolves every hazard, so the pipeline never stalls
  assign stall_c = 1'b0;
  assign fwd_a_c = hazard_a;
  assign fwd_b_c = hazard_b;
`else
  // A hazard on A, B or both costs one bubble; EX empties next cycle
  assign stall_c = hazard_a | hazard_b;
  assign fwd_a_c = 1'b0;
  assign fwd_b_c = 1'b0;
`endif

  assign issue = id_q.valid & ~stall_c;

  // Pipeline registers: ID holds while stalled, EX takes a bubble then
  always_ff @(posedge clk) begin
    if (reset) begin
      id_q <= '0;
      ex_q <= '0;
    end else begin
      if (!stall_c) begin
        id_q <= bus.inst_valid ? unpack_inst(inst) : '0;
      end
      if (issue) begin
        ex_q.valid <= 1'b1;
        ex_q.d     <= id_q.d;
      end else begin
        ex_q <= '0;
      end
    end
  end

  // Issue counter wraps; stall counter saturates at 255
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue) begin
        issue_cnt_q <= issue_cnt_q + 1'b1;
      end
      if (stall_c && (stall_cnt_q != 8'hFF)) begin
        stall_cnt_q <= stall_cnt_q + 8'd1;
      end
    end
  end

  assign bus.stall       = stall_c;
  assign bus.issue_valid = issue;
  assign bus.ctrl        = issue ? id_q.ctrl : 2'b00;
  assign bus.addr_a      = issue ? id_q.a : '0;
  assign bus.addr_b      = issue ? id_q.b : '0;
  assign bus.wb_en       = ex_q.valid;
  assign bus.wb_addr     = ex_q.d;
  assign bus.fwd_a       = fwd_a_c;
  assign bus.fwd_b       = fwd_b_c;
  assign bus.issue_count = issue_cnt_q;
  assign bus.stall_count = stall_cnt_q;

endmodule
